dmi_regfile_responder: RTL and testbench
========================================

// Module: dmi_regfile_responder
// PURPOSE
//  Core-side DMI target: consumes dm::dmi_req_t from the JTAG->core CDC, serves a bank of
//  32-bit scratch/mailbox registers, returns dm::dmi_resp_t through the core->JTAG CDC.
//  One outstanding request; fixed, programmable response latency; parallel HW update port
//  so core logic can post values for the debugger.
// PARAMETERS
//  NrRegs       8      number of 32-bit registers (1..32)
//  BaseAddr     7'h04  DMI address of reg[0]; reg[i] at BaseAddr+i (must not wrap past 7'h7F)
//  RespLatency  1      cycles from request accept to dmi_resp_valid_o (>=1)
// PORTS
//  clk_i             in   1          core clock
//  rst_ni            in   1          async active-low reset
//  dmi_req_i         in   dmi_req_t  {addr[6:0], op, data[31:0]}
//  dmi_req_valid_i   in   1          request valid
//  dmi_req_ready_o   out  1          request ready
//  dmi_resp_o        out  dmi_resp_t {data[31:0], resp[1:0]}
//  dmi_resp_valid_o  out  1          response valid
//  dmi_resp_ready_i  in   1          response ready
//  hw_we_i           in   NrRegs     per-register HW write enable
//  hw_wdata_i        in   NrRegs*32  per-register HW write data
//  regs_o            out  NrRegs*32  current register contents
// BEHAVIOUR
//  - Reset: all regs 0, FSM IDLE, dmi_req_ready_o=0 during reset then 1, dmi_resp_valid_o=0,
//    dmi_resp_o='0, counter 0.
//  - FSM IDLE -> WAIT -> RESP -> IDLE. ready_o=1 only in IDLE; accept = valid&ready.
//  - IDLE: on accept, decode and capture response {data,resp}; counter<=RespLatency-1;
//    go RESP if RespLatency==1 else WAIT. WAIT: count down, go RESP when counter==1.
//  - Latency: accept in cycle T -> dmi_resp_valid_o high from T+RespLatency.
//  - RESP: valid held, dmi_resp_o stable, until dmi_resp_ready_i; then IDLE (ready_o=1 next
//    cycle, i.e. one bubble; no back-to-back accept in the RESP-exit cycle).
//  - Decode: idx=addr-BaseAddr (7-bit), in range iff addr>=BaseAddr && idx<NrRegs.
//    READ in range: data=reg[idx] value before any same-cycle write, resp=DTM_SUCCESS.
//    WRITE in range: reg[idx]<=data at accept edge, resp data=0, DTM_SUCCESS.
//    NOP: no side effect, data=0, DTM_SUCCESS.
//    Out-of-range READ/WRITE or reserved op (2'b11): no side effect, data=0, resp=DTM_ERR.
//  - HW port: hw_we_i[i] loads reg[i] any cycle; same-cycle DMI write to same reg wins.
//    HW writes during WAIT/RESP do not alter a captured read response.
//  - regs_o is the registered state (updates visible one cycle after write edge).
//  - rst_ni assert mid-transaction: immediate return to reset values; any pending response
//    dropped (CDC side is reset by the same domain reset).
// CONFIGURATION
//  DMI_REGFILE_STICKY_ERR_EN:
//   defined: any DTM_ERR response sets sticky err_q; while err_q=1 every READ/WRITE returns
//    DTM_ERR, data 0, no side effect (HW port unaffected). A NOP clears err_q and responds
//    DTM_SUCCESS. err_q resets to 0.
//   undefined: no sticky state; each request decoded independently as above.
// TESTING
//  1 Reset release, RespLatency=1: WRITE addr 0x04 data 0xDEADBEEF -> resp_valid 1 cycle
//    after accept, DTM_SUCCESS, data 0; regs_o[0]=0xDEADBEEF; READ 0x04 -> 0xDEADBEEF.
//  2 RespLatency=4, hold dmi_resp_ready_i=0 for 10 cycles: valid rises exactly 4 cycles after
//    accept, dmi_resp_o stable, req_ready_o=0 throughout; ready released -> IDLE next cycle.
//  3 READ 0x03 and 0x0C (NrRegs=8), op 2'b11 to 0x04 -> DTM_ERR, data 0, regs unchanged;
//    with STICKY_ERR_EN a following READ 0x04 -> DTM_ERR, NOP -> SUCCESS, READ 0x04 -> SUCCESS.
//  4 Same cycle: DMI WRITE 0x05=0x11111111 and hw_we_i[1] with 0x22222222 -> reg[1]=0x11111111;
//    hw_we_i[1] next cycle with 0x33 -> regs_o[1]=0x33.
//  5 READ 0x06 accepted with reg[2]=0xA5A5A5A5, HW writes 0x5A5A5A5A during WAIT
//    (RespLatency=3) -> response data 0xA5A5A5A5.
//  6 Assert rst_ni while in RESP -> valid drops asynchronously, regs_o=0; post-reset READ 0x04
//    -> 0x00000000, DTM_SUCCESS.

Source files
------------

// File: rtl/dmi_regfile_responder.sv
// -----------------------------------------------------------------------------
// dmi_regfile_responder
//   Core-side DMI target. It takes requests coming out of the JTAG->core CDC,
//   serves a bank of 32-bit scratch/mailbox registers, and returns responses
//   towards the core->JTAG CDC. Only one request is in flight at a time. Each
//   response is presented a fixed number of cycles (RespLatency) after accept.
//   A parallel HW update port lets core logic post values for the debugger.
//
//   Parameters
//     NrRegs       number of 32-bit registers (1..32)
//     BaseAddr     DMI address of reg[0]; reg[i] sits at BaseAddr+i
//     RespLatency  cycles from request accept to dmi_resp_valid_o (>=1)
//
//   Ports
//     clk_i, rst_ni       core clock, async active-low reset
//     dmi_req_i           {addr[6:0], op[1:0], data[31:0]}
//     dmi_req_valid_i/_ready_o   request handshake (ready only in IDLE)
//     dmi_resp_o          {data[31:0], resp[1:0]}
//     dmi_resp_valid_o/_ready_i  response handshake
//     hw_we_i, hw_wdata_i per-register HW write enable / data
//     regs_o              registered register contents
//
//   Optional feature (macro DMI_REGFILE_STICKY_ERR_EN)
//     Any DTM_ERR response sets a sticky error flag. While the flag is set,
//     every READ/WRITE is refused with DTM_ERR. A NOP clears the flag.
// -----------------------------------------------------------------------------
package dm;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam logic [1:0] DTM_NOP     = 2'h0;
  localparam logic [1:0] DTM_READ    = 2'h1;
  localparam logic [1:0] DTM_WRITE   = 2'h2;
  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
endpackage

module dmi_regfile_responder #(
  parameter int unsigned NrRegs      = 8,
  parameter logic [6:0]  BaseAddr    = 7'h04,
  parameter int unsigned RespLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  dm::dmi_req_t           dmi_req_i,
  input  logic                   dmi_req_valid_i,
  output logic                   dmi_req_ready_o,
  output dm::dmi_resp_t          dmi_resp_o,
  output logic                   dmi_resp_valid_o,
  input  logic                   dmi_resp_ready_i,
  input  logic [NrRegs-1:0]      hw_we_i,
  input  logic [NrRegs*32-1:0]   hw_wdata_i,
  output logic [NrRegs*32-1:0]   regs_o
);

  localparam int unsigned CntW = (RespLatency > 1) ? $clog2(RespLatency) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  dm::dmi_resp_t            resp_q, resp_d;
  logic                     ready_q, ready_d;
  logic                     valid_q, valid_d;
  logic [NrRegs-1:0][31:0]  regs_q, regs_d;

  logic        accept_s;
  logic [6:0]  idx_s;
  logic        in_range_s;
  logic        is_rw_s;
  logic        blocked_s;
  logic        op_ok_s;
  logic        ok_s;
  logic [31:0] rd_data_s;
  logic [31:0] resp_data_s;
  logic [1:0]  resp_code_s;
  logic        wr_hit_s;

  assign accept_s   = dmi_req_valid_i & ready_q;
  // The subtraction is 7 bits wide, so addresses below BaseAddr wrap to large
  // values. The explicit lower-bound check keeps that wrap from aliasing.
  assign idx_s      = dmi_req_i.addr - BaseAddr;
  assign in_range_s = (dmi_req_i.addr >= BaseAddr) && (idx_s < 7'(NrRegs));
  assign is_rw_s    = (dmi_req_i.op == dm::DTM_READ) || (dmi_req_i.op == dm::DTM_WRITE);

`ifdef DMI_REGFILE_STICKY_ERR_EN
  logic err_q, err_d;

  assign blocked_s = err_q & is_rw_s;

  // Sticky error: set by any error response, cleared by an accepted NOP.
  always_comb begin
    err_d = err_q;
    err_d = !accept_s                    ? err_q :
            (resp_code_s == dm::DTM_ERR) ? 1'b1  :
            (dmi_req_i.op == dm::DTM_NOP) ? 1'b0 : err_q;
  end

  // Sticky error flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign blocked_s = 1'b0 & is_rw_s;
`endif

  // Request decode: read mux, legality check and the response to capture.
  always_comb begin
    rd_data_s = 32'h0;
    for (int i = 0; i < NrRegs; i++) begin
      rd_data_s = (idx_s == 7'(i)) ? regs_q[i] : rd_data_s;
    end
    case (dmi_req_i.op)
      dm::DTM_NOP:                op_ok_s = 1'b1;
      dm::DTM_READ, dm::DTM_WRITE: op_ok_s = in_range_s;
      default:                    op_ok_s = 1'b0;
    endcase
    ok_s        = op_ok_s & ~blocked_s;
    resp_code_s = ok_s ? dm::DTM_SUCCESS : dm::DTM_ERR;
    // regs_q is sampled here, so a read sees the value before any same-edge write.
    resp_data_s = (ok_s && (dmi_req_i.op == dm::DTM_READ)) ? rd_data_s : 32'h0;
    wr_hit_s    = accept_s & ok_s & (dmi_req_i.op == dm::DTM_WRITE);
  end

  // Register bank next state: HW port first, so a DMI write to the same register wins.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NrRegs; i++) begin
      regs_d[i] = hw_we_i[i] ? hw_wdata_i[i*32 +: 32] : regs_q[i];
      regs_d[i] = (wr_hit_s && (idx_s == 7'(i))) ? dmi_req_i.data : regs_d[i];
    end
  end

  // Transaction FSM: next state, latency counter and captured response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      StIdle: begin
        if (accept_s) begin
          resp_d  = '{data: resp_data_s, resp: resp_code_s};
          cnt_d   = CntW'(RespLatency - 1);
          state_d = (RespLatency == 1) ? StResp : StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d   = cnt_q - CntW'(1);
        state_d = (cnt_q == CntW'(1)) ? StResp : StWait;
      end
      StResp: begin
        state_d = dmi_resp_ready_i ? StIdle : StResp;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Handshake outputs are registered copies of the next-state decode. This
    // holds ready low through reset and for one cycle after RESP exits.
    ready_d = (state_d == StIdle);
    valid_d = (state_d == StResp);
  end

  // State, response and register bank flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      resp_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      regs_q  <= regs_d;
    end
  end

  assign dmi_req_ready_o  = ready_q;
  assign dmi_resp_valid_o = valid_q;
  assign dmi_resp_o       = resp_q;
  assign regs_o           = regs_q;

endmodule

// File: tb/tb_dmi_regfile_responder.sv
// -----------------------------------------------------------------------------
// tb_dmi_regfile_responder
//   Directed bench for dmi_regfile_responder. Three instances share the clock
//   and reset: index 0 uses RespLatency=1, index 1 uses 4, and index 2 uses 3.
//   All have NrRegs=8 and BaseAddr=0x04. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_dmi_regfile_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dm::dmi_req_t  req        [3];
  logic          req_valid  [3];
  logic          req_ready  [3];
  dm::dmi_resp_t resp       [3];
  logic          resp_valid [3];
  logic          resp_ready [3];
  logic [7:0]    hw_we      [3];
  logic [255:0]  hw_wdata   [3];
  logic [255:0]  regs       [3];

  int vec  = 0;
  int miss = 0;

  dmi_regfile_responder #(.NrRegs(8), .BaseAddr(7'h04), .RespLatency(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .dmi_req_i(req[0]), .dmi_req_valid_i(req_valid[0]),
    .dmi_req_ready_o(req_ready[0]), .dmi_resp_o(resp[0]), .dmi_resp_valid_o(resp_valid[0]),
    .dmi_resp_ready_i(resp_ready[0]), .hw_we_i(hw_we[0]), .hw_wdata_i(hw_wdata[0]),
    .regs_o(regs[0]));

  dmi_regfile_responder #(.NrRegs(8), .BaseAddr(7'h04), .RespLatency(4)) u_lat4 (
    .clk_i(clk), .rst_ni(rst_n), .dmi_req_i(req[1]), .dmi_req_valid_i(req_valid[1]),
    .dmi_req_ready_o(req_ready[1]), .dmi_resp_o(resp[1]), .dmi_resp_valid_o(resp_valid[1]),
    .dmi_resp_ready_i(resp_ready[1]), .hw_we_i(hw_we[1]), .hw_wdata_i(hw_wdata[1]),
    .regs_o(regs[1]));

  dmi_regfile_responder #(.NrRegs(8), .BaseAddr(7'h04), .RespLatency(3)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .dmi_req_i(req[2]), .dmi_req_valid_i(req_valid[2]),
    .dmi_req_ready_o(req_ready[2]), .dmi_resp_o(resp[2]), .dmi_resp_valid_o(resp_valid[2]),
    .dmi_resp_ready_i(resp_ready[2]), .hw_we_i(hw_we[2]), .hw_wdata_i(hw_wdata[2]),
    .regs_o(regs[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on instance k and return #1 after the accepting edge.
  task automatic send(input int k, input logic [1:0] op, input logic [6:0] addr,
                      input logic [31:0] data, input logic [7:0] hw_mask,
                      input logic [31:0] hw_val);
    int n;
    n = 0;
    @(negedge clk);
    req[k]       = '{addr: addr, op: op, data: data};
    req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 64'(n), 64'd0);
    end
    hw_we[k] = hw_mask;
    for (int i = 0; i < 8; i++) hw_wdata[k][i*32 +: 32] = hw_val;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    hw_we[k]     = 8'h00;
  endtask

  // Count cycles from accept until resp_valid, and note if req_ready rose meanwhile.
  task automatic wait_resp(input int k, output int lat, output dm::dmi_resp_t r,
                           output logic rdy_low);
    int n;
    n = 1;
    rdy_low = 1'b1;
    while (!resp_valid[k] && n < 20) begin
      if (req_ready[k]) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    r   = resp[k];
  endtask

  task automatic consume(input int k);
    resp_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
  endtask

  task automatic txn(input int k, input string tag, input logic [1:0] op,
                     input logic [6:0] addr, input logic [31:0] data, input int exp_lat,
                     input logic [31:0] exp_data, input logic [1:0] exp_code);
    int            lat;
    dm::dmi_resp_t r;
    logic          rl;
    send(k, op, addr, data, 8'h00, 32'h0);
    wait_resp(k, lat, r, rl);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_resp"}, 64'(r), {30'h0, exp_data, exp_code});
    consume(k);
  endtask

  initial begin
    int            lat;
    dm::dmi_resp_t r, r0;
    logic          rl, stable;

    for (int k = 0; k < 3; k++) begin
      req[k] = '0; req_valid[k] = 1'b0; resp_ready[k] = 1'b0;
      hw_we[k] = 8'h00; hw_wdata[k] = '0;
    end
    #2 rst_n = 1'b0;
    #20;
    chk("rst_req_ready", 64'(req_ready[0]), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("rst_resp", 64'(resp[0]), 64'd0);
    chk("rst_regs", 64'(regs[0] != 256'h0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(req_ready[0]), 64'd1);

    // 1: basic write/read, latency 1
    txn(0, "t1_wr", dm::DTM_WRITE, 7'h04, 32'hDEADBEEF, 1, 32'h0, dm::DTM_SUCCESS);
    chk("t1_regs0", 64'(regs[0][31:0]), 64'hDEADBEEF);
    txn(0, "t1_rd", dm::DTM_READ, 7'h04, 32'h0, 1, 32'hDEADBEEF, dm::DTM_SUCCESS);
    txn(0, "t1_rd_last", dm::DTM_READ, 7'h0B, 32'h0, 1, 32'h0, dm::DTM_SUCCESS);

    // 2: latency 4 with backpressure on the response
    send(1, dm::DTM_WRITE, 7'h07, 32'hCAFEF00D, 8'h00, 32'h0);
    wait_resp(1, lat, r0, rl);
    chk("t2_lat", 64'(lat), 64'd4);
    chk("t2_ready_low_wait", 64'(rl), 64'd1);
    chk("t2_resp", 64'(r0), {30'h0, 32'h0, dm::DTM_SUCCESS});
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!resp_valid[1] || (resp[1] !== r0) || req_ready[1]) stable = 1'b0;
    end
    chk("t2_hold_stable", 64'(stable), 64'd1);
    consume(1);
    chk("t2_ready_after", 64'(req_ready[1]), 64'd1);
    chk("t2_valid_after", 64'(resp_valid[1]), 64'd0);
    txn(1, "t2_rd", dm::DTM_READ, 7'h07, 32'h0, 4, 32'hCAFEF00D, dm::DTM_SUCCESS);

    // 3: out-of-range and reserved op
    txn(0, "t3_rd_lo", dm::DTM_READ, 7'h03, 32'h0, 1, 32'h0, dm::DTM_ERR);
    txn(0, "t3_rd_hi", dm::DTM_READ, 7'h0C, 32'h0, 1, 32'h0, dm::DTM_ERR);
    txn(0, "t3_wr_hi", dm::DTM_WRITE, 7'h0C, 32'h12345678, 1, 32'h0, dm::DTM_ERR);
    txn(0, "t3_rsvd", 2'b11, 7'h04, 32'h55555555, 1, 32'h0, dm::DTM_ERR);
    chk("t3_regs_unch", 64'(regs[0][63:0]), 64'h00000000DEADBEEF);
`ifdef DMI_REGFILE_STICKY_ERR_EN
    txn(0, "t3_sticky_rd", dm::DTM_READ, 7'h04, 32'h0, 1, 32'h0, dm::DTM_ERR);
    txn(0, "t3_nop", dm::DTM_NOP, 7'h00, 32'h0, 1, 32'h0, dm::DTM_SUCCESS);
`endif
    txn(0, "t3_rd_ok", dm::DTM_READ, 7'h04, 32'h0, 1, 32'hDEADBEEF, dm::DTM_SUCCESS);

    // 4: DMI write and HW write collide on reg[1]
    send(0, dm::DTM_WRITE, 7'h05, 32'h11111111, 8'h02, 32'h22222222);
    wait_resp(0, lat, r, rl);
    chk("t4_resp", 64'(r), {30'h0, 32'h0, dm::DTM_SUCCESS});
    consume(0);
    chk("t4_dmi_wins", 64'(regs[0][63:32]), 64'h11111111);
    @(negedge clk);
    hw_we[0] = 8'h02;
    hw_wdata[0][63:32] = 32'h00000033;
    @(posedge clk);
    #1;
    hw_we[0] = 8'h00;
    chk("t4_hw_write", 64'(regs[0][63:32]), 64'h00000033);

    // 5: HW write during WAIT leaves captured read data alone
    txn(2, "t5_wr", dm::DTM_WRITE, 7'h06, 32'hA5A5A5A5, 3, 32'h0, dm::DTM_SUCCESS);
    send(2, dm::DTM_READ, 7'h06, 32'h0, 8'h00, 32'h0);
    hw_we[2] = 8'h04;
    hw_wdata[2][95:64] = 32'h5A5A5A5A;
    wait_resp(2, lat, r, rl);
    hw_we[2] = 8'h00;
    chk("t5_lat", 64'(lat), 64'd3);
    chk("t5_resp", 64'(r), {30'h0, 32'hA5A5A5A5, dm::DTM_SUCCESS});
    chk("t5_regs2", 64'(regs[2][95:64]), 64'h5A5A5A5A);
    consume(2);

    // 6: reset while a response is pending
    send(0, dm::DTM_READ, 7'h04, 32'h0, 8'h00, 32'h0);
    wait_resp(0, lat, r, rl);
    chk("t6_pre_valid", 64'(resp_valid[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", 64'(resp_valid[0]), 64'd0);
    chk("t6_regs_zero", 64'(regs[0] != 256'h0), 64'd0);
    chk("t6_ready_low", 64'(req_ready[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    txn(0, "t6_rd", dm::DTM_READ, 7'h04, 32'h0, 1, 32'h0, dm::DTM_SUCCESS);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
